// File: rtl/tlb_cam_plru_pkg.sv
// Shared types for the TLB CAM: entry record and SFENCE.VMA flush kinds.
// Entry fields use maximum widths so one record type serves every parameter set.
package tlb_cam_plru_pkg;

   localparam int MAX_KEY_W  = 64;
   localparam int MAX_ASID_W = 16;
   localparam int MAX_PT_W   = 4;

   // Encoding is {UseVA, UseASID} so the request bits cast directly.
   typedef enum logic [1:0] {
      SF_ALL     = 2'b00,
      SF_ASID    = 2'b01,
      SF_VA      = 2'b10,
      SF_VA_ASID = 2'b11
   } sfence_kind_t;

   typedef struct packed {
      logic                  valid;
      logic [MAX_KEY_W-1:0]  key;
      logic [MAX_ASID_W-1:0] asid;
      logic                  g;
      logic [MAX_PT_W-1:0]   pt;
   } tlb_entry_t;

endpackage

// File: rtl/tlb_cam_plru_tree.sv
// Tree pseudo-LRU over TLB_ENTRIES leaves: node bit 0 steers the victim to the
// lower half, 1 to the upper half; an access points every node on its path away.
module tlb_plru_tree #(
   parameter int TLB_ENTRIES = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [TLB_ENTRIES-1:0] access_i,
   input  logic                   update_i,
   output logic [TLB_ENTRIES-1:0] victim_o
);
   localparam int DEPTH = $clog2(TLB_ENTRIES);

   logic [TLB_ENTRIES-1:1] plru_q, plru_d;
   logic [DEPTH-1:0]       idx;

   always_comb begin
      idx = '0;
      for (int e = 0; e < TLB_ENTRIES; e++)
         if (access_i[e]) idx = idx | DEPTH'(e);
   end

   // Node (1<<l)+k covers leaves whose top l index bits equal k.
   always_comb begin
      plru_d = plru_q;
      for (int l = 0; l < DEPTH; l++)
         for (int k = 0; k < (1 << l); k++)
            if (update_i && ((int'(idx) >> (DEPTH - l)) == k))
               plru_d[(1 << l) + k] = ~idx[DEPTH-1-l];
   end

   always_comb begin
      for (int e = 0; e < TLB_ENTRIES; e++) begin
         victim_o[e] = 1'b1;
         for (int l = 0; l < DEPTH; l++)
            if (plru_q[(1 << l) + (e >> (DEPTH - l))] != 1'((e >> (DEPTH - 1 - l))))
               victim_o[e] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) plru_q <= '0;
      else       plru_q <= plru_d;
   end

endmodule

// File: rtl/tlb_cam_plru.sv
// Fully associative TLB CAM with ASID tags, tree-PLRU replacement and SFENCE.VMA.
// Define TLB_SELECTIVE_SFENCE_EN for VA/ASID-selective flush; otherwise any sfence flushes all.
module tlb_cam_plru
   import tlb_cam_plru_pkg::*;
#(
   parameter int TLB_ENTRIES = 8,
   parameter int LEVELS      = 3,
   parameter int SEG_BITS    = 9,
   parameter int ASID_BITS   = 16,
   parameter int PT_BITS     = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [LEVELS*SEG_BITS-1:0] VPN,
   input  logic [PT_BITS-1:0]         ActiveLevels,
   input  logic [ASID_BITS-1:0]       SATP_ASID,
   input  logic                       LookupValid,
   input  logic                       WriteEn,
   input  logic                       WriteG,
   input  logic [PT_BITS-1:0]         PageTypeWriteVal,
   input  logic                       SfenceValid,
   input  logic                       SfenceUseVA,
   input  logic                       SfenceUseASID,
   input  logic [ASID_BITS-1:0]       SfenceASID,
   output logic [TLB_ENTRIES-1:0]     Matches,
   output logic                       CAMHit,
   output logic [PT_BITS-1:0]         HitPageType,
   output logic [TLB_ENTRIES-1:0]     Victim,
   output logic                       MultiHit
);
   localparam int KEY_W = LEVELS * SEG_BITS;

   tlb_entry_t [TLB_ENTRIES-1:0] entries_q, entries_d;

   logic [TLB_ENTRIES-1:0] key_hit, valid_vec, inv, plru_victim, access, flush;
   logic [MAX_KEY_W-1:0]   vpn_ext;
   logic [MAX_ASID_W-1:0]  asid_ext;
   logic                   plru_upd;

   assign vpn_ext  = MAX_KEY_W'(VPN);
   assign asid_ext = MAX_ASID_W'(SATP_ASID);

`ifdef TLB_SELECTIVE_SFENCE_EN
   logic [TLB_ENTRIES-1:0] sf_asid_hit;
   sfence_kind_t           sf_kind;
`endif

   for (genvar e = 0; e < TLB_ENTRIES; e++) begin : g_line
      logic [MAX_KEY_W-1:0] care;

      // A key bit participates only if its segment is at or above the leaf level
      // and inside the active translation depth.
      always_comb begin
         care = '0;
         for (int j = 0; j < KEY_W; j++)
            care[j] = ((j / SEG_BITS) >= int'(entries_q[e].pt)) &&
                      ((j / SEG_BITS) < int'(ActiveLevels));
      end

      assign key_hit[e]   = ((entries_q[e].key ^ vpn_ext) & care) == '0;
      assign valid_vec[e] = entries_q[e].valid;
      assign Matches[e]   = entries_q[e].valid & key_hit[e] &
                            (entries_q[e].g | (entries_q[e].asid == asid_ext));
`ifdef TLB_SELECTIVE_SFENCE_EN
      assign sf_asid_hit[e] = ~entries_q[e].g &
                              (entries_q[e].asid == MAX_ASID_W'(SfenceASID));
`endif
   end

   assign CAMHit   = |Matches & ~SfenceValid;
   assign MultiHit = |(Matches & (Matches - TLB_ENTRIES'(1)));

   always_comb begin
      HitPageType = '0;
      for (int e = 0; e < TLB_ENTRIES; e++)
         if (Matches[e]) HitPageType = HitPageType | entries_q[e].pt[PT_BITS-1:0];
   end

`ifdef TLB_SELECTIVE_SFENCE_EN
   assign sf_kind = sfence_kind_t'({SfenceUseVA, SfenceUseASID});

   always_comb begin
      flush = '0;
      if (SfenceValid) begin
         unique case (sf_kind)
            SF_ALL:     flush = '1;
            SF_VA:      flush = key_hit;
            SF_ASID:    flush = sf_asid_hit;
            SF_VA_ASID: flush = key_hit & sf_asid_hit;
         endcase
      end
   end
`else
   logic unused_sfence;
   assign unused_sfence = ^{SfenceUseVA, SfenceUseASID, SfenceASID};
   assign flush         = {TLB_ENTRIES{SfenceValid}};
`endif

   // Fill holes lowest-first; the PLRU tree only chooses once the CAM is full.
   assign inv    = ~valid_vec;
   assign Victim = |inv ? (inv & (~inv + TLB_ENTRIES'(1))) : plru_victim;

   assign access   = WriteEn ? Victim : Matches;
   assign plru_upd = WriteEn | (LookupValid & CAMHit);

   tlb_plru_tree #(.TLB_ENTRIES(TLB_ENTRIES)) u_plru (
      .clk      (clk),
      .reset    (reset),
      .access_i (access),
      .update_i (plru_upd),
      .victim_o (plru_victim)
   );

   // Flush first so a write landing in a flushed slot still ends valid.
   always_comb begin
      entries_d = entries_q;
      for (int e = 0; e < TLB_ENTRIES; e++) begin
         if (flush[e]) entries_d[e].valid = 1'b0;
         if (WriteEn && Victim[e]) begin
            entries_d[e].valid = 1'b1;
            entries_d[e].key   = vpn_ext;
            entries_d[e].asid  = asid_ext;
            entries_d[e].g     = WriteG;
            entries_d[e].pt    = MAX_PT_W'(PageTypeWriteVal);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int e = 0; e < TLB_ENTRIES; e++) entries_q[e].valid <= 1'b0;
      end else begin
         entries_q <= entries_d;
      end
   end

endmodule
